// File: rtl/loop_seq_pkg.sv
// ---------------------------------------------------------------------------
// loop_seq_pkg
// Shared definitions for the nested-loop sequencer slice: the controller
// state encoding and the default index widths used by loop_sequencer and
// loop_index_ctr.
// ---------------------------------------------------------------------------
package loop_seq_pkg;

    // Controller states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seqState_e;

    localparam int DEFAULT_ROW_W = 4;
    localparam int DEFAULT_COL_W = 4;

endpackage

// File: rtl/loop_index_ctr.sv
// ---------------------------------------------------------------------------
// loop_index_ctr
// One loop index: a WIDTH-bit counter that counts up from 0 to max_i and
// wraps back to 0 on the next enabled step. Used twice by loop_sequencer,
// once for the row and once for the column.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous active-high reset (index -> 0)
//   clr_i     in   1      synchronous clear to 0, wins over en_i
//   en_i      in   1      advance one step
//   max_i     in   WIDTH  last index value (inclusive)
//   idx_o     out  WIDTH  current index
//   atMax_o   out  1      idx_o equals max_i
// ---------------------------------------------------------------------------
module loop_index_ctr
    import loop_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] idx_o,
    output logic             atMax_o
);

    logic [WIDTH-1:0] idx_q;
    logic [WIDTH-1:0] idx_d;

    // Equality compare only: an all-ones bound is reached without overflow.
    assign atMax_o = (idx_q == max_i);
    assign idx_o   = idx_q;

    // Next index: clear has priority, otherwise step or wrap at the bound.
    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i) begin
            if (atMax_o) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + WIDTH'(1);
            end
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// ---------------------------------------------------------------------------
// loop_sequencer
// Two-level nested-loop controller. After start it walks (row, col) from
// (0,0) to the latched bounds, column innermost, presenting one index pair
// per non-stalled cycle to the datapath, then pulses done for one cycle.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start_i    in   1      request a sweep (sampled in IDLE)
//   stall_i    in   1      datapath back-pressure: hold indices, drop valid
//   abort_i    in   1      cancel an active sweep (no done pulse)
//   rowMax_i   in   ROW_W  last row index, latched at start
//   colMax_i   in   COL_W  last col index, latched at start
//   busy_o     out  1      sweep in progress
//   valid_o    out  1      indices carry a live iteration this cycle
//   rowIdx_o   out  ROW_W  current row index
//   colIdx_o   out  COL_W  current col index
//   first_o    out  1      live iteration is (0,0)
//   last_o     out  1      live iteration is (rowMax, colMax)
//   done_o     out  1      one-cycle pulse after the final iteration
//
// Build option
//   LOOP_SEQUENCER_AUTO_RESTART_EN: when defined, start seen during the
//   done cycle launches the next sweep directly, skipping the idle cycle.
// ---------------------------------------------------------------------------
module loop_sequencer
    import loop_seq_pkg::*;
#(
    parameter int ROW_W = DEFAULT_ROW_W,
    parameter int COL_W = DEFAULT_COL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             abort_i,
    input  logic [ROW_W-1:0] rowMax_i,
    input  logic [COL_W-1:0] colMax_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [ROW_W-1:0] rowIdx_o,
    output logic [COL_W-1:0] colIdx_o,
    output logic             first_o,
    output logic             last_o,
    output logic             done_o
);

    seqState_e        state_q;
    seqState_e        state_d;
    logic [ROW_W-1:0] rowMax_q;
    logic [ROW_W-1:0] rowMax_d;
    logic [COL_W-1:0] colMax_q;
    logic [COL_W-1:0] colMax_d;

    logic             ctrClr;
    logic             colEn;
    logic             rowEn;
    logic             colAtMax;
    logic             rowAtMax;

    // Column index: the inner loop.
    loop_index_ctr #(
        .WIDTH (COL_W)
    ) u_colCtr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (ctrClr),
        .en_i    (colEn),
        .max_i   (colMax_q),
        .idx_o   (colIdx_o),
        .atMax_o (colAtMax)
    );

    // Row index: steps only when the column wraps.
    loop_index_ctr #(
        .WIDTH (ROW_W)
    ) u_rowCtr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (ctrClr),
        .en_i    (rowEn),
        .max_i   (rowMax_q),
        .idx_o   (rowIdx_o),
        .atMax_o (rowAtMax)
    );

    // Next-state and counter control. Counters are held clear outside RUN so
    // every sweep begins at (0,0); DONE keeps the final pair visible for its
    // single cycle and clears on the way out. On the final iteration the
    // counters are not enabled, so the indices never wrap back to (0,0).
    always_comb begin
        state_d  = state_q;
        rowMax_d = rowMax_q;
        colMax_d = colMax_q;
        ctrClr   = 1'b0;
        colEn    = 1'b0;
        rowEn    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ctrClr = 1'b1;
                if (start_i) begin
                    rowMax_d = rowMax_i;
                    colMax_d = colMax_i;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    ctrClr  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!stall_i) begin
                    if (colAtMax && rowAtMax) begin
                        state_d = ST_DONE;
                    end else begin
                        colEn = 1'b1;
                        rowEn = colAtMax;
                    end
                end
            end
            ST_DONE: begin
                ctrClr  = 1'b1;
                state_d = ST_IDLE;
`ifdef LOOP_SEQUENCER_AUTO_RESTART_EN
                if (start_i) begin
                    rowMax_d = rowMax_i;
                    colMax_d = colMax_i;
                    state_d  = ST_RUN;
                end
`endif
            end
            default: begin
                ctrClr  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-bound registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rowMax_q <= '0;
            colMax_q <= '0;
        end else begin
            state_q  <= state_d;
            rowMax_q <= rowMax_d;
            colMax_q <= colMax_d;
        end
    end

    // Output decode from the registered state and indices; valid also
    // follows the live stall input so a stalled cycle is never consumed.
    assign busy_o  = (state_q == ST_RUN);
    assign valid_o = busy_o && !stall_i;
    assign first_o = valid_o && (rowIdx_o == '0) && (colIdx_o == '0);
    assign last_o  = valid_o && rowAtMax && colAtMax;
    assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_loop_sequencer
// Self-checking bench for loop_sequencer. The reference model expands each
// sweep into a queue of expected (row, col) pairs and consumes one pair per
// non-stalled cycle; directed sweeps are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_loop_sequencer;

    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stall;
    logic             abort;
    logic [ROW_W-1:0] rowMax;
    logic [COL_W-1:0] colMax;
    logic             busy;
    logic             valid;
    logic [ROW_W-1:0] rowIdx;
    logic [COL_W-1:0] colIdx;
    logic             first;
    logic             last;
    logic             done;

    loop_sequencer #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .stall_i  (stall),
        .abort_i  (abort),
        .rowMax_i (rowMax),
        .colMax_i (colMax),
        .busy_o   (busy),
        .valid_o  (valid),
        .rowIdx_o (rowIdx),
        .colIdx_o (colIdx),
        .first_o  (first),
        .last_o   (last),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } IdxPair;

    int     checkCount = 0;
    int     errorCount = 0;
    IdxPair pending[$];
    IdxPair lastIssued;
    int     modelPhase;
    int     validCount;
    int     doneCount;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Expand a whole sweep into the ordered list of iterations it must issue.
    function automatic void loadSweep(input int rm, input int cm);
        IdxPair p;
        pending.delete();
        for (int r = 0; r <= rm; r++) begin
            for (int c = 0; c <= cm; c++) begin
                p.row = ROW_W'(r);
                p.col = COL_W'(c);
                pending.push_back(p);
            end
        end
    endfunction

    // One clock cycle: drive inputs, compare against the model, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input logic s, input logic st, input logic ab,
                                 input int rm, input int cm);
        int expRow;
        int expCol;
        int expValid;
        @(negedge clk);
        start  = s;
        stall  = st;
        abort  = ab;
        rowMax = ROW_W'(rm);
        colMax = COL_W'(cm);
        #1;
        expValid = (modelPhase == 1 && !st) ? 1 : 0;
        if (modelPhase == 1) begin
            expRow = int'(pending[0].row);
            expCol = int'(pending[0].col);
        end else if (modelPhase == 2) begin
            expRow = int'(lastIssued.row);
            expCol = int'(lastIssued.col);
        end else begin
            expRow = 0;
            expCol = 0;
        end
        checkOutput("busy", int'(busy), (modelPhase == 1) ? 1 : 0);
        checkOutput("valid", int'(valid), expValid);
        checkOutput("rowIdx", int'(rowIdx), expRow);
        checkOutput("colIdx", int'(colIdx), expCol);
        checkOutput("first", int'(first), (expValid == 1 && expRow == 0 && expCol == 0) ? 1 : 0);
        checkOutput("last", int'(last), (expValid == 1 && pending.size() == 1) ? 1 : 0);
        checkOutput("done", int'(done), (modelPhase == 2) ? 1 : 0);
        validCount += int'(valid);
        doneCount  += int'(done);
        @(posedge clk);
        case (modelPhase)
            0: begin
                if (s) begin
                    loadSweep(rm, cm);
                    modelPhase = 1;
                end
            end
            1: begin
                if (ab) begin
                    pending.delete();
                    modelPhase = 0;
                end else if (!st) begin
                    lastIssued = pending.pop_front();
                    if (pending.size() == 0) modelPhase = 2;
                end
            end
            default: begin
                modelPhase = 0;
`ifdef LOOP_SEQUENCER_AUTO_RESTART_EN
                if (s) begin
                    loadSweep(rm, cm);
                    modelPhase = 1;
                end
`endif
            end
        endcase
    endtask

    // Run idle cycles with scrambled bounds to prove they were latched.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end
    endtask

    task automatic resetCounts();
        validCount = 0;
        doneCount  = 0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        abort      = 1'b0;
        rowMax     = '0;
        colMax     = '0;
        modelPhase = 0;
        lastIssued = '0;
        resetCounts();

        // Reset state.
        @(negedge clk);
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_idx", int'({rowIdx, colIdx}), 0);
        checkOutput("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        // 2x3 sweep.
        $display("[TB] sweep 1x2");
        resetCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1, 2);
        idleCycles(9);
        checkOutput("t1_validCount", validCount, 6);
        checkOutput("t1_doneCount", doneCount, 1);

        // Same sweep with a two-cycle stall at (0,2).
        $display("[TB] sweep with stall");
        resetCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3, 3);
        idleCycles(8);
        checkOutput("t2_validCount", validCount, 6);
        checkOutput("t2_doneCount", doneCount, 1);

        // Single-iteration sweep.
        $display("[TB] sweep 0x0");
        resetCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        idleCycles(4);
        checkOutput("t3_validCount", validCount, 1);
        checkOutput("t3_doneCount", doneCount, 1);

        // Full-range sweep.
        $display("[TB] sweep 15x15");
        resetCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 15, 15);
        idleCycles(262);
        checkOutput("t4_validCount", validCount, 256);
        checkOutput("t4_doneCount", doneCount, 1);

        // Abort at (1,0) while also stalled: abort wins, no done pulse.
        $display("[TB] abort");
        resetCounts();
        applyStimulus(1'b1, 1'b0, 1'b0, 1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1, 2);
        idleCycles(5);
        checkOutput("t5_validCount", validCount, 3);
        checkOutput("t5_doneCount", doneCount, 0);

        // Reset in the middle of a sweep clears outputs immediately.
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 3, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 3, 3);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_valid", int'(valid), 0);
        checkOutput("mid_rst_idx", int'({rowIdx, colIdx}), 0);
        checkOutput("mid_rst_done", int'(done), 0);
        pending.delete();
        modelPhase = 0;
        @(negedge clk);
        rst = 1'b0;
        idleCycles(2);

        // Start held high across done: restart timing depends on build option.
        $display("[TB] start held through done");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 1);
        end
        idleCycles(4);

        // Randomized traffic with changing bounds, stalls and aborts.
        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            logic s;
            logic st;
            logic ab;
            int   rm;
            int   cm;
            s  = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 39) == 0);
            rm = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
            cm = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
            applyStimulus(s, st, ab, rm, cm);
        end
        idleCycles(300);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
